// File: rtl/cgra_launch_pkg.sv
// Shared types, default widths and helpers for the CGRA kernel launcher.
package cgra_launch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int              DEF_CNT_WIDTH      = 16;
  localparam int              DEF_FIFO_DEPTH     = 4;
  localparam int              DEF_TOTAL_WIDTH    = 32;
  localparam int              DEF_TIMEOUT_WIDTH  = 24;
  localparam logic [23:0]     DEF_TIMEOUT_CYCLES = 24'hFFFFFF;

  // Helper operates on a wide carrier so any counter width up to SAT_W fits.
  localparam int SAT_W = 64;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                input logic [SAT_W-1:0] max_val);
    return (val == max_val) ? val : val + SAT_W'(1);
  endfunction

endpackage

// File: rtl/cgra_launch_fifo.sv
// Request queue: synchronous FIFO with occupancy output. DEPTH must be a
// power of two so the pointers wrap naturally. No bypass: a word written at
// one edge is readable only after that edge.
module cgra_launch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next pointers, storage and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control registers; cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cgra_launch_ctrl.sv
// Host-side CGRA kernel launcher: queues repeat-count requests and drives the
// Computation_Start/Computation_Done 4-phase handshake.
// Optional watchdog: define CGRA_LAUNCH_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | Start low; pops a request once the CGRA has dropped Done
// ASSERT  | Start high (from 2nd cycle); waits for Done high
// RELEASE | Start low; waits for Done low, then retires one run
module cgra_launch_ctrl
  import cgra_launch_pkg::*;
#(
  parameter int                       CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int                       FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int                       TOTAL_WIDTH    = DEF_TOTAL_WIDTH,
  parameter int                       TIMEOUT_WIDTH  = DEF_TIMEOUT_WIDTH,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            Req_Valid,
  output logic                            Req_Ready,
  input  logic [CNT_WIDTH-1:0]            Req_Count,
  output logic                            Computation_Start,
  input  logic                            Computation_Done,
  output logic                            Busy,
  output logic                            Run_Done_Pulse,
  output logic                            Req_Done_Pulse,
  output logic [TOTAL_WIDTH-1:0]          Run_Total,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] Fifo_Level,
  output logic                            Timeout_Err,
  input  logic                            Err_Clear
);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   rem_q, rem_d;
  logic                   start_q, start_d;
  logic                   run_pulse_q, run_pulse_d;
  logic                   req_pulse_q, req_pulse_d;
  logic [TOTAL_WIDTH-1:0] run_total_q, run_total_d;
  logic [SAT_W-1:0]       total_wide;
  logic [SAT_W-TOTAL_WIDTH-1:0] total_wide_unused;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [CNT_WIDTH-1:0]   fifo_rdata;
`ifdef CGRA_LAUNCH_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic                     err_q, err_d;
  logic                     tmo_hit;
`endif

  cgra_launch_fifo #(
    .WIDTH (CNT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (Req_Valid),
    .wdata (Req_Count),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (Fifo_Level)
  );

  assign Req_Ready         = ~fifo_full;
  assign Busy              = (state_q != IDLE) | ~fifo_empty;
  assign Computation_Start = start_q;
  assign Run_Done_Pulse    = run_pulse_q;
  assign Req_Done_Pulse    = req_pulse_q;
  assign Run_Total         = run_total_q;

  // Saturating run counter increment, evaluated on a wide carrier.
  always_comb begin
    total_wide = sat_inc(SAT_W'(run_total_q), SAT_W'({TOTAL_WIDTH{1'b1}}));
  end
  assign total_wide_unused = total_wide[SAT_W-1:TOTAL_WIDTH];

  // Handshake sequencing, run bookkeeping and registered output values.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    run_pulse_d = 1'b0;
    req_pulse_d = 1'b0;
    run_total_d = run_total_q;
    fifo_pop    = 1'b0;
`ifdef CGRA_LAUNCH_TIMEOUT_EN
    tmo_hit     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !Computation_Done) begin
          fifo_pop = 1'b1;
          if (fifo_rdata == '0) begin
            req_pulse_d = 1'b1;
          end else begin
            rem_d   = fifo_rdata;
            state_d = ASSERT;
          end
        end
      end
      ASSERT: begin
        // Done only counts as an acknowledge once Start is actually visible.
        if (start_q && Computation_Done) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!Computation_Done) begin
          run_pulse_d = 1'b1;
          run_total_d = total_wide[TOTAL_WIDTH-1:0];
          rem_d       = rem_q - CNT_WIDTH'(1);
          if (rem_q == CNT_WIDTH'(1)) begin
            req_pulse_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = ASSERT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef CGRA_LAUNCH_TIMEOUT_EN
    // A completing handshake edge wins over an expiring watchdog.
    if (state_q != IDLE && state_d == state_q && wd_q == '0) begin
      tmo_hit = 1'b1;
      state_d = IDLE;
      rem_d   = '0;
    end
`endif
    // Start rises one cycle into ASSERT and never while a stale Done is high.
    start_d = (state_q == ASSERT) && (state_d == ASSERT) &&
              (start_q || !Computation_Done);
  end

  // FSM and counter registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      start_q     <= 1'b0;
      run_pulse_q <= 1'b0;
      req_pulse_q <= 1'b0;
      run_total_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      start_q     <= start_d;
      run_pulse_q <= run_pulse_d;
      req_pulse_q <= req_pulse_d;
      run_total_q <= run_total_d;
    end
  end

`ifdef CGRA_LAUNCH_TIMEOUT_EN
  // Watchdog down-counter reloaded on every state change; sticky error flag.
  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q) begin
      wd_d = TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1);
    end else if (wd_q != '0) begin
      wd_d = wd_q - TIMEOUT_WIDTH'(1);
    end
    err_d = err_q;
    if (Err_Clear) begin
      err_d = 1'b0;
    end
    if (tmo_hit) begin
      err_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wd_q  <= TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1);
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign Timeout_Err = err_q;
`else
  logic tmo_unused;
  assign tmo_unused  = ^{Err_Clear, TIMEOUT_CYCLES};
  assign Timeout_Err = 1'b0;
`endif

endmodule

// File: tb/tb_cgra_launch_ctrl.sv
// Directed self-checking bench for cgra_launch_ctrl. The CGRA is modelled as
// manual Done (mode 0), Done = Start (mode 1) or Done = Start delayed 2 cycles
// (mode 2). Watchdog expectations follow CGRA_LAUNCH_TIMEOUT_EN.
module tb_cgra_launch_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, start, done, busy;
  logic        run_p, req_p, tmo_err, err_clear;
  logic [15:0] req_count;
  logic [31:0] run_total;
  logic [2:0]  fifo_level;

  logic        done_man, s1, s2;
  int          mode;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    s1 <= start;
    s2 <= s1;
  end
  assign done = (mode == 1) ? start : (mode == 2) ? s2 : done_man;

  cgra_launch_ctrl #(
    .CNT_WIDTH      (16),
    .FIFO_DEPTH     (4),
    .TOTAL_WIDTH    (32),
    .TIMEOUT_WIDTH  (24),
    .TIMEOUT_CYCLES (24'd16)
  ) dut (
    .Clk               (clk),
    .Rst               (rst),
    .Req_Valid         (req_valid),
    .Req_Ready         (req_ready),
    .Req_Count         (req_count),
    .Computation_Start (start),
    .Computation_Done  (done),
    .Busy              (busy),
    .Run_Done_Pulse    (run_p),
    .Req_Done_Pulse    (req_p),
    .Run_Total         (run_total),
    .Fifo_Level        (fifo_level),
    .Timeout_Err       (tmo_err),
    .Err_Clear         (err_clear)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = 1'b0; req_count = '0; err_clear = 1'b0;
    done_man = 1'b0; mode = 0;
    tick(); tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_start(input int max_cyc, input string name);
    for (int i = 0; i < max_cyc && start !== 1'b1; i++) tick();
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL %s: start=%b want 1 (timed out)", name, start); end
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (run_p !== 1'b0 || req_p !== 1'b0) begin errors++; $display("FAIL rst_pulses: got %b%b want 00", run_p, req_p); end
    checks++; if (run_total !== 32'd0) begin errors++; $display("FAIL rst_total: got %0d want 0", run_total); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", tmo_err); end
  endtask

  task automatic test_single_run;
    int nruns = 0, nreqs = 0, ncoinc = 0;
    do_reset();
    mode = 2;
    req_valid = 1'b1; req_count = 16'd1;
    tick();                                   // edge t: accepted
    req_valid = 1'b0;
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level_t: got %0d want 1", fifo_level); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_t: got %b want 1", busy); end
    tick();                                   // edge t+1: popped
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL single_start_t1: got %b want 0", start); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_level_t1: got %0d want 0", fifo_level); end
    tick();                                   // edge t+2: Start high
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL single_start_t2: got %b want 1", start); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (run_p) nruns++;
      if (req_p) nreqs++;
      if (run_p && req_p) ncoinc++;
    end
    checks++; if (nruns != 1) begin errors++; $display("FAIL single_runs: got %0d want 1", nruns); end
    checks++; if (nreqs != 1) begin errors++; $display("FAIL single_reqs: got %0d want 1", nreqs); end
    checks++; if (ncoinc != 1) begin errors++; $display("FAIL single_coincident: got %0d want 1", ncoinc); end
    checks++; if (run_total !== 32'd1) begin errors++; $display("FAIL single_total: got %0d want 1", run_total); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int nstarts = 0, nruns = 0, nreqs = 0, bad = 0, req1 = -1, req2 = -1;
    logic prev_start, prev_done;
    do_reset();
    mode = 1;
    req_valid = 1'b1; req_count = 16'd3;
    tick();
    req_count = 16'd2;
    tick();
    req_valid = 1'b0;
    prev_start = start; prev_done = done;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (start && !prev_start) begin
        nstarts++;
        if (prev_done) bad++;
      end
      if (run_p) nruns++;
      if (req_p) begin
        nreqs++;
        if (nreqs == 1) req1 = nruns;
        if (nreqs == 2) req2 = nruns;
      end
      prev_start = start; prev_done = done;
    end
    checks++; if (nstarts != 5) begin errors++; $display("FAIL b2b_starts: got %0d want 5", nstarts); end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_start_while_done: got %0d want 0", bad); end
    checks++; if (nreqs != 2) begin errors++; $display("FAIL b2b_reqs: got %0d want 2", nreqs); end
    checks++; if (req1 != 3) begin errors++; $display("FAIL b2b_req1_at_run: got %0d want 3", req1); end
    checks++; if (req2 != 5) begin errors++; $display("FAIL b2b_req2_at_run: got %0d want 5", req2); end
    checks++; if (run_total !== 32'd5) begin errors++; $display("FAIL b2b_total: got %0d want 5", run_total); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_queue_full;
    int nreqs = 0;
    do_reset();
    done_man = 1'b1;                          // stale Done holds the queue
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_count = 16'(i + 1);
      tick();
    end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d want 4", fifo_level); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", req_ready); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL full_start: got %b want 0", start); end
    req_count = 16'd9;
    tick();
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_5th_push: level %0d want 4", fifo_level); end
    done_man = 1'b0;                          // pop and push attempt together
    tick();
    req_valid = 1'b0;
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL full_push_on_pop: level %0d want 3", fifo_level); end
    mode = 1;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (req_p) nreqs++;
    end
    checks++; if (nreqs != 4) begin errors++; $display("FAIL full_drain_reqs: got %0d want 4", nreqs); end
    checks++; if (run_total !== 32'd10) begin errors++; $display("FAIL full_drain_total: got %0d want 10", run_total); end
  endtask

  task automatic test_count_zero_stale_done;
    int nst = 0;
    do_reset();
    req_valid = 1'b1; req_count = 16'd0;
    tick();
    req_valid = 1'b0;
    tick();
    checks++; if (req_p !== 1'b1) begin errors++; $display("FAIL zero_req_pulse: got %b want 1", req_p); end
    checks++; if (run_p !== 1'b0 || start !== 1'b0) begin errors++; $display("FAIL zero_no_run: run %b start %b want 0 0", run_p, start); end
    tick();
    checks++; if (req_p !== 1'b0) begin errors++; $display("FAIL zero_pulse_width: got %b want 0", req_p); end
    checks++; if (busy !== 1'b0 || run_total !== 32'd0) begin errors++; $display("FAIL zero_idle: busy %b total %0d want 0 0", busy, run_total); end
    done_man = 1'b1;
    req_valid = 1'b1; req_count = 16'd1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (start) nst++;
    end
    checks++; if (nst != 0) begin errors++; $display("FAIL stale_no_start: got %0d starts want 0", nst); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL stale_level: got %0d want 1", fifo_level); end
    done_man = 1'b0;
    tick();
    checks++; if (fifo_level !== 3'd0 || start !== 1'b0) begin errors++; $display("FAIL stale_pop: level %0d start %b want 0 0", fifo_level, start); end
    tick();
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL stale_start: got %b want 1", start); end
  endtask

  task automatic test_reset_mid_run;
    do_reset();
    req_valid = 1'b1; req_count = 16'd5;
    tick();
    req_count = 16'd2;
    tick();
    tick();
    req_valid = 1'b0;
    wait_start(5, "mid_first_start");
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    tick();
    checks++; if (run_total !== 32'd1) begin errors++; $display("FAIL mid_total_pre: got %0d want 1", run_total); end
    wait_start(5, "mid_second_start");
    done_man = 1'b1;
    tick();                                   // now in RELEASE
    checks++; if (start !== 1'b0 || fifo_level !== 3'd2) begin errors++; $display("FAIL mid_pre_reset: start %b level %0d want 0 2", start, fifo_level); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL mid_rst_start: got %b want 0", start); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_rst_level: got %0d want 0", fifo_level); end
    checks++; if (run_total !== 32'd0) begin errors++; $display("FAIL mid_rst_total: got %0d want 0", run_total); end
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_flags: busy %b ready %b want 0 1", busy, req_ready); end
    done_man = 1'b0;
  endtask

  task automatic test_timeout;
    int nhigh = 0, nreqs = 0;
    do_reset();
    req_valid = 1'b1; req_count = 16'd3;
    tick();                                   // edge t
    req_count = 16'd1;
    tick();                                   // edge t+1: pop, enter ASSERT
    req_valid = 1'b0;
    for (int i = 2; i <= 17; i++) begin       // edges t+2 .. t+17
      tick();
      if (start) nhigh++;
      if (req_p) nreqs++;
    end
    checks++; if (nreqs != 0) begin errors++; $display("FAIL tmo_no_req_pulse: got %0d want 0", nreqs); end
`ifdef CGRA_LAUNCH_TIMEOUT_EN
    // ASSERT cycle 1 has Start low; abort at the edge ending cycle TMO.
    checks++; if (nhigh != TMO - 1) begin errors++; $display("FAIL tmo_start_cycles: got %0d want %0d", nhigh, TMO - 1); end
    checks++; if (start !== 1'b0 || tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_abort: start %b err %b want 0 1", start, tmo_err); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL tmo_queue_kept: got %0d want 1", fifo_level); end
    tick();
    checks++; if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", tmo_err); end
    tick();
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL tmo_next_launch: got %b want 1", start); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", tmo_err); end
`else
    checks++; if (nhigh != TMO) begin errors++; $display("FAIL notmo_start_cycles: got %0d want %0d", nhigh, TMO); end
    checks++; if (start !== 1'b1 || tmo_err !== 1'b0) begin errors++; $display("FAIL notmo_hold: start %b err %b want 1 0", start, tmo_err); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++; if (tmo_err !== 1'b0 || start !== 1'b1) begin errors++; $display("FAIL notmo_clear: err %b start %b want 0 1", tmo_err, start); end
`endif
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_count = '0; err_clear = 1'b0;
    done_man = 1'b0; mode = 0;
    test_reset();
    test_single_run();
    test_back_to_back();
    test_queue_full();
    test_count_zero_stale_done();
    test_reset_mid_run();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
